// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Package : dmem_pkg -- shared types and constants for the dmem responder
// Rev     : 1.0
// ============================================================================
package dmem_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_WAIT = 3'd1,
        WR_RESP = 3'd2,
        RD_WAIT = 3'd3,
        RD_RESP = 3'd4
    } state_t;

    localparam int          DEFAULT_LATENCY  = 3;
    localparam int          DEFAULT_DEPTH    = 4096;
    localparam int          DEFAULT_AW       = 16;
    localparam int          CNT_W            = 4;
    localparam logic [31:0] OOR_READ_PATTERN = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Interface : dmem_responder_if -- request/response bus between dcache and memory
// Rev       : 1.0
// ============================================================================
interface dmem_responder_if #(
    parameter int AW = 16
);
    logic          rden;
    logic [AW-1:0] rdaddress;
    logic          wren;
    logic [AW-1:0] wraddress;
    logic [31:0]   write_data;
    logic          ready;
    logic [31:0]   read_data;
    logic          rd_valid;
    logic          wr_ack;
    logic          err;

    modport master (
        output rden, rdaddress, wren, wraddress, write_data,
        input  ready, read_data, rd_valid, wr_ack, err
    );

    modport slave (
        input  rden, rdaddress, wren, wraddress, write_data,
        output ready, read_data, rd_valid, wr_ack, err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module : dmem_array -- DEPTH x 32 single-port synchronous RAM, registered read
// Rev    : 1.0
// ============================================================================
module dmem_array #(
    parameter int DEPTH = 4096,
    parameter int IW    = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic [IW-1:0] addr,
    input  wire logic          we,
    input  wire logic [31:0]   wdata,
    input  wire logic          re,
    output logic      [31:0]   rdata
);
    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    // Output register only updates on re, so it holds the last word read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= r_mem[addr];
        end
    end
endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module : dmem_responder -- fixed-latency memory responder for dcache refill/writeback
//          Optional macro DMEM_OOR_ERR_EN enables out-of-range detection and err.
// Rev    : 1.0
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int AW      = DEFAULT_AW
) (
    input wire logic         clk,
    input wire logic         rst,
    dmem_responder_if.slave  bus
);
    localparam int              c_iw       = $clog2(DEPTH);
    localparam int              c_xw       = AW - 2;
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(LATENCY - 1);

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_rd_pend, w_rd_pend_nxt;
    logic [c_xw-1:0]   r_wr_word, r_rd_word;
    logic [31:0]       r_wr_data;
    logic              w_accept, w_ready, w_wr_ack, w_rd_valid;
    logic              w_ram_we, w_ram_re, w_wr_oor, w_err;
    logic [c_iw-1:0]   w_ram_addr;
    logic [31:0]       w_ram_rdata;
    logic              w_unused_bits;

    assign w_accept = (r_state == IDLE) && (bus.rden || bus.wren);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rd_pend <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rd_pend <= w_rd_pend_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_word <= '0;
            r_rd_word <= '0;
            r_wr_data <= '0;
        end else if (w_accept) begin
            r_wr_word <= bus.wraddress[AW-1:2];
            r_rd_word <= bus.rdaddress[AW-1:2];
            r_wr_data <= bus.write_data;
        end
    end

    // A combined request always services the write first, then the read.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rd_pend_nxt = r_rd_pend;
        w_ready       = 1'b0;
        w_wr_ack      = 1'b0;
        w_rd_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.wren) begin
                    w_state_nxt   = WR_WAIT;
                    w_cnt_nxt     = c_cnt_load;
                    w_rd_pend_nxt = bus.rden;
                end else if (bus.rden) begin
                    w_state_nxt = RD_WAIT;
                    w_cnt_nxt   = c_cnt_load;
                end
            end
            WR_WAIT: begin
                if (r_cnt == '0) w_state_nxt = WR_RESP;
                else             w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
            WR_RESP: begin
                w_wr_ack = 1'b1;
                if (r_rd_pend) begin
                    w_state_nxt   = RD_WAIT;
                    w_cnt_nxt     = c_cnt_load;
                    w_rd_pend_nxt = 1'b0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RD_WAIT: begin
                if (r_cnt == '0) w_state_nxt = RD_RESP;
                else             w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
            RD_RESP: begin
                w_rd_valid  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The RAM read is launched in the last wait cycle so data lands with RD_RESP.
    assign w_ram_re   = (r_state == RD_WAIT) && (r_cnt == '0);
    assign w_ram_we   = (r_state == WR_RESP) && !w_wr_oor;
    assign w_ram_addr = (r_state == WR_RESP) ? r_wr_word[c_iw-1:0] : r_rd_word[c_iw-1:0];

    dmem_array #(
        .DEPTH (DEPTH),
        .IW    (c_iw)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .addr  (w_ram_addr),
        .we    (w_ram_we),
        .wdata (r_wr_data),
        .re    (w_ram_re),
        .rdata (w_ram_rdata)
    );

`ifdef DMEM_OOR_ERR_EN
    localparam logic [c_xw:0] c_depth = (c_xw + 1)'(DEPTH);
    logic w_rd_oor;
    logic r_rd_oor_q;

    assign w_wr_oor = {1'b0, r_wr_word} >= c_depth;
    assign w_rd_oor = {1'b0, r_rd_word} >= c_depth;

    // Tracks the range status of the word currently held in the RAM output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_oor_q <= 1'b0;
        end else if (w_ram_re) begin
            r_rd_oor_q <= w_rd_oor;
        end
    end

    assign w_err         = (w_wr_ack && w_wr_oor) || (w_rd_valid && r_rd_oor_q);
    assign bus.read_data = r_rd_oor_q ? OOR_READ_PATTERN : w_ram_rdata;
`else
    assign w_wr_oor      = 1'b0;
    assign w_err         = 1'b0;
    assign bus.read_data = w_ram_rdata;
`endif

    assign bus.ready    = w_ready;
    assign bus.wr_ack   = w_wr_ack;
    assign bus.rd_valid = w_rd_valid;
    assign bus.err      = w_err;

    assign w_unused_bits = ^{bus.rdaddress[1:0], bus.wraddress[1:0], r_wr_word, r_rd_word};
endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the data-cache refill/writeback port.
- Accepts one read and/or one write request per handshake.
- Models a fixed access latency and returns data or an acknowledge with a one-cycle pulse.
- Replaces the zero-latency data memory behind dcache so the cache miss path is exercised with realistic multi-cycle memory timing.

Parameters:
- LATENCY, 3: cycles from request acceptance to response pulse; legal range 1..15.
- DEPTH, 4096: number of 32-bit words stored.
- AW, 16: byte-address width of rdaddress/wraddress.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rden  in  1  read request.
- rdaddress  in  AW  read byte address; word index = rdaddress[AW-1:2].
- wren  in  1  write request.
- wraddress  in  AW  write byte address; word index = wraddress[AW-1:2].
- write_data  in  32  write word.
- ready  out  1  responder idle; a request is accepted only when ready=1.
- read_data  out  32  read word; valid only while rd_valid=1.
- rd_valid  out  1  one-cycle pulse, read data returned.
- wr_ack  out  1  one-cycle pulse, write committed.
- err  out  1  one-cycle pulse alongside rd_valid/wr_ack (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rst=0, async): ready=1, rd_valid=0, wr_ack=0, read_data=0, err=0, FSM=IDLE, latency counter=0, pending flags cleared. Array contents are not reset.
- Acceptance:
  - Occurs on the rising edge where ready=1 and (rden|wren)=1.
  - Addresses, write_data and request type are latched at that edge.
  - Requests presented while ready=0 are ignored, not queued; the requester holds them until ready=1.
- FSM states: IDLE, WR_WAIT, WR_RESP, RD_WAIT, RD_RESP.
  - IDLE: ready=1.
    - wren only -> WR_WAIT.
    - rden only -> RD_WAIT.
    - Both -> WR_WAIT with rd_pend=1. Write is always serviced first.
  - WR_WAIT:
    - Counter loads LATENCY-1 on entry and decrements.
    - At 0 -> WR_RESP.
  - WR_RESP:
    - Array[wr_idx] <= wr_data_q; wr_ack=1 for this cycle.
    - If rd_pend=1 -> RD_WAIT (counter reloads LATENCY-1) and rd_pend clears; else -> IDLE.
  - RD_WAIT: same counting as WR_WAIT; at 0 -> RD_RESP.
  - RD_RESP:
    - read_data=Array[rd_idx] (registered output), rd_valid=1 for this cycle.
    - -> IDLE; ready=1 on the following cycle.
- ready=0 in every state except IDLE.
- Latency:
  - Write only: wr_ack asserts exactly LATENCY cycles after the accepting edge.
  - Read only: rd_valid asserts exactly LATENCY cycles after the accepting edge.
  - Combined request: wr_ack at LATENCY, rd_valid at 2*LATENCY+1.
- Read-after-write, same word (combined or back-to-back): the read returns the newly written data.
- read_data holds its last value after the rd_valid pulse; it changes only in RD_RESP.
- LATENCY=1: the WAIT states last one cycle (counter loads 0).
- Mid-operation reset: the transaction is abandoned, no ack is emitted, and an in-flight write is not committed unless WR_RESP had already completed.
- Address wrap (feature off): word index is taken modulo DEPTH (low log2(DEPTH) bits).

Optional Feature:
- Macro: DMEM_OOR_ERR_EN.
- Defined:
  - A latched word index >= DEPTH flags the transaction out-of-range.
  - The write is suppressed but wr_ack still pulses.
  - A read returns 32'hDEAD_BEEF.
  - err=1 in the same cycle as the wr_ack/rd_valid pulse.
  - In a combined request, each half is checked independently.
- Undefined: no range check, indices wrap modulo DEPTH, err tied 0.

Decomposition:
- Shared package dmem_pkg holds:
  - FSM state enum (IDLE, WR_WAIT, WR_RESP, RD_WAIT, RD_RESP).
  - Default LATENCY/DEPTH constants.
  - OOR_READ_PATTERN=32'hDEAD_BEEF.
  - Latency-counter width constant (4 bits).
- One sub-module: dmem_array, a single-port synchronous word RAM (DEPTH x 32, write enable, registered read). The responder instantiates it once and owns all timing and handshake logic.

Test Plan:
- Write only: LATENCY=3, wren with wraddress=16'h0010, write_data=32'h1234_5678 at t0 -> ready=0 at t0+1, wr_ack pulse at t0+3, ready=1 at t0+4.
- Read only after the write: rden with rdaddress=16'h0010 -> rd_valid pulse 3 cycles later with read_data=32'h1234_5678; read_data unchanged afterwards.
- Combined request: rden+wren same edge, both addresses 16'h0020, write_data=32'hCAFE_F00D -> wr_ack at +3, rd_valid at +7 with 32'hCAFE_F00D.
- Request while busy: rden pulsed during WR_WAIT -> ignored, no extra rd_valid; LATENCY=1 -> wr_ack exactly 1 cycle after acceptance.
- Reset mid-read: rst=0 during RD_WAIT -> rd_valid never pulses, ready=1 immediately, read_data=0; a new read after release succeeds.
- DMEM_OOR_ERR_EN with DEPTH=4096, wraddress=16'h4000, then read 16'h4000 -> wr_ack+err, then rd_valid+err with 32'hDEAD_BEEF; word 0 unchanged. With the macro off, the same write lands in word 0.
